fetch_unit: RTL and testbench

Instruction fetch stage that owns the program counter, drives `pc_address` into the combinational instruction memory and registers the returned byte into an instruction register for the decode/execute stage. It advances the PC by 2 per fetch, redirects on taken branches reported by execute, detects the HALT opcode (0xFF), and freezes until reset. It sits directly upstream of the instruction memory (address side) and between it and decode (data side).

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, instruction register, branch redirect, HALT freeze
//
// Optional feature macro: FETCH_PERF_CNT_EN (builds the fetch performance counter).
//
// Ports:
//   clk            in   1  system clock, rising edge
//   rst            in   1  synchronous active-high reset
//   stall          in   1  decode/execute cannot accept a new instruction
//   branch_taken   in   1  instruction in instr_out resolved as a taken branch
//   branch_target  in   8  absolute branch target (bit 0 ignored)
//   instr_in       in   8  instruction byte from combinational memory at pc_address
//   pc_address     out  8  registered fetch address
//   instr_out      out  8  registered instruction for decode
//   instr_pc       out  8  address instr_out was fetched from
//   instr_valid    out  1  instr_out is a real instruction, not a bubble
//   halted         out  1  HALT fetched, stage frozen until reset
//   fetch_count    out 16  saturating count of valid fetches (0 when counter not built)

module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  input  logic [7:0]  instr_in,
  output logic [7:0]  pc_address,
  output logic [7:0]  instr_out,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [7:0] HALT_OPCODE = 8'hFF;
  localparam logic [7:0] NOP_OPCODE  = 8'h00;
  localparam logic [7:0] PC_STEP     = 8'd2;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  ipc_q, ipc_d;
  logic        valid_q, valid_d;

  // A branch can only be resolved against a real instruction; a taken flag
  // during a bubble has nothing to redirect and falls through to stall/fetch.
  logic branch_go;
  logic do_fetch;
  logic halt_hit;

  assign branch_go = (state_q == S_FETCH) && branch_taken && valid_q;
  assign do_fetch  = (state_q == S_FETCH) && !branch_go && !stall;
  assign halt_hit  = do_fetch && (instr_in == HALT_OPCODE);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= 8'h00;
      ir_q    <= NOP_OPCODE;
      ipc_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (halt_hit) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    case (state_q)
      S_FETCH: begin
        if (branch_go) begin
          // Wrong-path byte on instr_in is dropped; one bubble follows.
          pc_d    = {branch_target[7:1], 1'b0};
          valid_d = 1'b0;
        end else if (do_fetch) begin
          ir_d    = instr_in;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          // HALT parks the PC on the HALT address instead of advancing.
          if (!halt_hit) pc_d = pc_q + PC_STEP;
        end
      end
      S_HALT: begin
        // HALT stays visible until decode accepts it, then becomes a bubble.
        if (!stall) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign pc_address  = pc_q;
  assign instr_out   = ir_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else if (do_fetch && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural reference model

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [7:0]  instr_in;
  logic [7:0]  pc_address;
  logic [7:0]  instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0]  mem [256];

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [7:0]  m_pc = 8'h00;
  logic [7:0]  m_out = 8'h00;
  logic [7:0]  m_ipc = 8'h00;
  logic        m_valid = 1'b0;
  logic        m_halted = 1'b0;
  logic [15:0] m_cnt = 16'h0000;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_in      (instr_in),
    .pc_address    (pc_address),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  assign instr_in = mem[pc_address];

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_count();
`ifdef FETCH_PERF_CNT_EN
    return m_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // Apply the fetch rules for one edge using the inputs currently driven.
  task automatic model_step();
    logic [7:0] b;
    b = mem[m_pc];
    if (rst) begin
      m_pc = 8'h00; m_out = 8'h00; m_ipc = 8'h00;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0000;
    end else if (m_halted) begin
      if (!stall) m_valid = 1'b0;
    end else if (branch_taken && m_valid) begin
      m_pc = branch_target & 8'hFE;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_out = b;
      m_ipc = m_pc;
      m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (b == 8'hFF) m_halted = 1'b1;
      else m_pc = m_pc + 8'd2;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input bit zero);
    for (int i = 0; i < 256; i++) begin
      if (zero) mem[i] = 8'h00;
      else mem[i] = 8'($urandom_range(0, 254));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fill_mem(1'b0);
    do_reset();
    tests++;
    if ({pc_address, instr_out, instr_pc, instr_valid, halted, fetch_count} !== 42'h0) begin
      fails++;
      $display("FAIL reset_values got pc=%h out=%h ipc=%h v=%b h=%b cnt=%h want all zero",
               pc_address, instr_out, instr_pc, instr_valid, halted, fetch_count);
    end
  endtask

  task automatic test_halt_freerun();
    logic [7:0] exp_pc;
    fill_mem(1'b1);
    mem[8'h12] = 8'hFF;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_pc = (k == 10) ? 8'h12 : 8'(2 * k);
      tests++;
      if (pc_address !== exp_pc || instr_pc !== 8'(2 * (k - 1)) || instr_valid !== 1'b1) begin
        fails++;
        $display("FAIL halt_run_k%0d got pc=%h ipc=%h v=%b want pc=%h ipc=%h v=1",
                 k, pc_address, instr_pc, instr_valid, exp_pc, 8'(2 * (k - 1)));
      end
    end
    tests++;
    if (halted !== 1'b1 || instr_out !== 8'hFF) begin
      fails++;
      $display("FAIL halt_entry got h=%b out=%h want h=1 out=ff", halted, instr_out);
    end
    tick();
    tests++;
    if (instr_valid !== 1'b0 || halted !== 1'b1 || pc_address !== 8'h12) begin
      fails++;
      $display("FAIL halt_drop got v=%b h=%b pc=%h want v=0 h=1 pc=12", instr_valid, halted, pc_address);
    end
    for (int k = 0; k < 5; k++) begin
      stall = 1'($urandom); branch_taken = 1'($urandom); branch_target = 8'($urandom);
      tick();
      tests++;
      if (pc_address !== 8'h12 || instr_valid !== 1'b0 || halted !== 1'b1 || instr_pc !== 8'h12) begin
        fails++;
        $display("FAIL halt_frozen_%0d got pc=%h v=%b h=%b ipc=%h want pc=12 v=0 h=1 ipc=12",
                 k, pc_address, instr_valid, halted, instr_pc);
      end
    end
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_branch();
    fill_mem(1'b0);
    do_reset();
    repeat (3) tick();
    tests++;
    if (instr_pc !== 8'h04 || instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL branch_setup got ipc=%h v=%b want ipc=04 v=1", instr_pc, instr_valid);
    end
    branch_taken = 1'b1; branch_target = 8'h0D;
    tick();
    branch_taken = 1'b0;
    tests++;
    if (pc_address !== 8'h0C || instr_valid !== 1'b0 || instr_pc !== 8'h04) begin
      fails++;
      $display("FAIL branch_bubble got pc=%h v=%b ipc=%h want pc=0c v=0 ipc=04", pc_address, instr_valid, instr_pc);
    end
    tick();
    tests++;
    if (instr_pc !== 8'h0C || instr_valid !== 1'b1 || instr_out !== mem[8'h0C] || pc_address !== 8'h0E) begin
      fails++;
      $display("FAIL branch_target got ipc=%h v=%b out=%h pc=%h want ipc=0c v=1 out=%h pc=0e",
               instr_pc, instr_valid, instr_out, pc_address, mem[8'h0C]);
    end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    fill_mem(1'b0);
    do_reset();
    repeat (3) tick();
    held = instr_out;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (pc_address !== 8'h06 || instr_out !== held || instr_valid !== 1'b1 || instr_out !== mem[8'h04]) begin
        fails++;
        $display("FAIL stall_hold_%0d got pc=%h out=%h v=%b want pc=06 out=%h v=1",
                 k, pc_address, instr_out, instr_valid, mem[8'h04]);
      end
    end
    stall = 1'b0;
    tick();
    tests++;
    if (instr_pc !== 8'h06 || pc_address !== 8'h08 || instr_out !== mem[8'h06]) begin
      fails++;
      $display("FAIL stall_resume got ipc=%h pc=%h out=%h want ipc=06 pc=08 out=%h",
               instr_pc, pc_address, instr_out, mem[8'h06]);
    end
  endtask

  task automatic test_branch_vs_halt();
    fill_mem(1'b0);
    mem[8'h08] = 8'hFF;
    do_reset();
    repeat (4) tick();
    branch_taken = 1'b1; branch_target = 8'h00;
    tick();
    branch_taken = 1'b0;
    tests++;
    if (pc_address !== 8'h00 || halted !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL branch_beats_halt got pc=%h h=%b v=%b want pc=00 h=0 v=0", pc_address, halted, instr_valid);
    end
    tick();
    tests++;
    if (instr_pc !== 8'h00 || halted !== 1'b0 || instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL branch_beats_halt_next got ipc=%h h=%b v=%b want ipc=00 h=0 v=1", instr_pc, halted, instr_valid);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want;
    fill_mem(1'b1);
    do_reset();
    repeat (127) tick();
    tests++;
    if (pc_address !== 8'hFE) begin
      fails++;
      $display("FAIL wrap_pre got pc=%h want fe", pc_address);
    end
    tick();
    tests++;
    if (pc_address !== 8'h00 || instr_pc !== 8'hFE) begin
      fails++;
      $display("FAIL wrap_post got pc=%h ipc=%h want pc=00 ipc=fe", pc_address, instr_pc);
    end
    tick();
`ifdef FETCH_PERF_CNT_EN
    want = 16'd129;
`else
    want = 16'd0;
`endif
    tests++;
    if (fetch_count !== want || instr_pc !== 8'h00 || pc_address !== 8'h02) begin
      fails++;
      $display("FAIL wrap_count got cnt=%0d ipc=%h pc=%h want cnt=%0d ipc=00 pc=02",
               fetch_count, instr_pc, pc_address, want);
    end
  endtask

  task automatic test_reset_in_halt();
    fill_mem(1'b1);
    mem[8'h12] = 8'hFF;
    do_reset();
    repeat (12) tick();
    tests++;
    if (halted !== 1'b1) begin
      fails++;
      $display("FAIL rih_halted got h=%b want 1", halted);
    end
    do_reset();
    tests++;
    if ({pc_address, instr_out, instr_pc, instr_valid, halted, fetch_count} !== 42'h0) begin
      fails++;
      $display("FAIL rih_reset got pc=%h out=%h ipc=%h v=%b h=%b cnt=%h want all zero",
               pc_address, instr_out, instr_pc, instr_valid, halted, fetch_count);
    end
    tick();
    tests++;
    if (instr_pc !== 8'h00 || instr_valid !== 1'b1 || pc_address !== 8'h02 || halted !== 1'b0) begin
      fails++;
      $display("FAIL rih_restart got ipc=%h v=%b pc=%h h=%b want ipc=00 v=1 pc=02 h=0",
               instr_pc, instr_valid, pc_address, halted);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst           = ($urandom_range(0, 39) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      branch_target = 8'($urandom);
      tick();
      tests++;
      if ({pc_address, instr_out, instr_pc, instr_valid, halted, fetch_count} !==
          {m_pc, m_out, m_ipc, m_valid, m_halted, exp_count()}) begin
        fails++;
        $display("FAIL random_%0d got pc=%h out=%h ipc=%h v=%b h=%b cnt=%h want pc=%h out=%h ipc=%h v=%b h=%b cnt=%h",
                 k, pc_address, instr_out, instr_pc, instr_valid, halted, fetch_count,
                 m_pc, m_out, m_ipc, m_valid, m_halted, exp_count());
      end
    end
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    fill_mem(1'b1);
    #1;
    test_reset();
    test_halt_freerun();
    test_branch();
    test_stall();
    test_branch_vs_halt();
    test_wrap();
    test_reset_in_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
